// File: rtl/game_pkg.sv
// Shared encodings and geometry for the game display path.
// Contents: game state encodings, VGA timing/active-area constants,
// frame-buffer geometry, fade FSM encoding and a background-address helper.
package game_pkg;

    localparam int unsigned CNT_W      = 10;
    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned H_TOTAL    = 800;
    localparam int unsigned V_TOTAL    = 525;
    localparam int unsigned FB_W       = 320;
    localparam int unsigned FB_H       = 240;
    localparam int unsigned BG_ADDR_W  = 17;

    typedef enum logic [3:0] {
        GS_TITLE    = 4'd0,
        GS_STAFF    = 4'd1,
        GS_STAGE1   = 4'd2,
        GS_SUCCESS1 = 4'd3,
        GS_STAGE2   = 4'd4,
        GS_SUCCESS2 = 4'd5,
        GS_STAGE3   = 4'd6,
        GS_SUCCESS3 = 4'd7,
        GS_FAIL     = 4'd8
    } game_state_e;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } fade_state_e;

    // Background is the 320x240 frame buffer scaled 2x in both directions.
    function automatic logic [BG_ADDR_W-1:0] bg_addr(input logic [CNT_W-1:0] h,
                                                     input logic [CNT_W-1:0] v);
        logic [BG_ADDR_W-1:0] row;
        row = BG_ADDR_W'(v >> 1);
        return BG_ADDR_W'(h >> 1) + (row * BG_ADDR_W'(FB_W));
    endfunction

endpackage

// File: rtl/layer_prio_enc.sv
// Combinational priority encoder: lowest-index hit wins.
// Ports:
//   hit_i   qualified hit vector, bit 0 = highest priority
//   addr_i  per-layer addresses, layer k in slice k
//   any_c   at least one layer hit
//   idx_c   index of the winning layer (0 when none)
//   addr_c  address of the winning layer (0 when none)
module layer_prio_enc #(
    parameter  int unsigned N_LAYERS = 4,
    parameter  int unsigned ADDR_W   = 17,
    localparam int unsigned IDX_W    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic [N_LAYERS-1:0]        hit_i,
    input  logic [N_LAYERS*ADDR_W-1:0] addr_i,
    output logic                       any_c,
    output logic [IDX_W-1:0]           idx_c,
    output logic [ADDR_W-1:0]          addr_c
);

    // Scan from the lowest priority upward so the lowest index overwrites last.
    always_comb begin
        any_c  = 1'b0;
        idx_c  = '0;
        addr_c = '0;
        for (int k = int'(N_LAYERS) - 1; k >= 0; k--) begin
            if (hit_i[k]) begin
                any_c  = 1'b1;
                idx_c  = IDX_W'(k);
                addr_c = addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/game_layer_compositor.sv
// Per-pixel layer compositor between VGA timing and frame-memory address.
// Two-stage pipeline (inputs -> stage 1 -> outputs). Game state is latched
// only at the frame boundary (h_cnt == 0 && v_cnt == 0), and every scene
// change blanks the screen for FADE_FRAMES frames.
// Optional feature macro: LAYER_BLINK_EN (blink layers in blink_mask with a
// half-period of BLINK_FRAMES frames). Without it blink_mask is ignored.
// Ports:
//   clk, rst       pixel clock, asynchronous active-high reset
//   state          requested game state
//   h_cnt, v_cnt   raster position
//   layer_en       per-layer enable
//   layer_hit      per-layer coverage of this pixel
//   layer_addr     per-layer address, layer k in slice k
//   blink_mask     layers subject to blinking
//   pixel_addr     frame-memory address
//   pixel_src      0 = background, k = layer k-1
//   pixel_valid    active area and not blanked
//   frame_start    pulse aligned with output pixel (0,0)
//   shown_state    state being displayed
//   blanking       fade in progress
module game_layer_compositor
    import game_pkg::*;
#(
    parameter  int unsigned N_LAYERS     = 4,
    parameter  int unsigned ADDR_W       = 17,
    parameter  int unsigned STATE_W      = 4,
    parameter  int unsigned FADE_FRAMES  = 8,
    parameter  int unsigned BLINK_FRAMES = 16,
    localparam int unsigned SRC_W        = $clog2(N_LAYERS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STATE_W-1:0]         state,
    input  logic [CNT_W-1:0]           h_cnt,
    input  logic [CNT_W-1:0]           v_cnt,
    input  logic [N_LAYERS-1:0]        layer_en,
    input  logic [N_LAYERS-1:0]        layer_hit,
    input  logic [N_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic [N_LAYERS-1:0]        blink_mask,
    output logic [ADDR_W-1:0]          pixel_addr,
    output logic [SRC_W-1:0]           pixel_src,
    output logic                       pixel_valid,
    output logic                       frame_start,
    output logic [STATE_W-1:0]         shown_state,
    output logic                       blanking
);

    localparam int unsigned IDX_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int unsigned FADE_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    logic                fb_c;
    logic                active_c;
    logic                enter_show_c;
    logic [N_LAYERS-1:0] hide_c;

    fade_state_e         fsm_q, fsm_d;
    logic [STATE_W-1:0]  shown_q, shown_d;
    logic [FADE_W-1:0]   fade_cnt_q, fade_cnt_d;

    logic [N_LAYERS-1:0]        hit1_q;
    logic [N_LAYERS*ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0]          bg1_q;
    logic                       active1_q;
    logic                       fb1_q;

    logic                sel_any_c;
    logic [IDX_W-1:0]    sel_idx_c;
    logic [ADDR_W-1:0]   sel_addr_c;

    logic [ADDR_W-1:0]   pixel_addr_d;
    logic [SRC_W-1:0]    pixel_src_d;
    logic                pixel_valid_d;

    assign fb_c     = (h_cnt == '0) && (v_cnt == '0);
    assign active_c = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));

    // Fade FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= SHOW;
            shown_q    <= '0;
            fade_cnt_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            shown_q    <= shown_d;
            fade_cnt_q <= fade_cnt_d;
        end
    end

    // Fade FSM next state; acts only on the frame-boundary input cycle.
    always_comb begin
        fsm_d        = fsm_q;
        shown_d      = shown_q;
        fade_cnt_d   = fade_cnt_q;
        enter_show_c = 1'b0;
        if (fb_c) begin
            unique case (fsm_q)
                SHOW: begin
                    if (state != shown_q) begin
                        shown_d = state;
                        if (FADE_FRAMES > 0) begin
                            fade_cnt_d = FADE_W'(FADE_FRAMES - 1);
                            fsm_d      = BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (state != shown_q) begin
                        shown_d    = state;
                        fade_cnt_d = FADE_W'(FADE_FRAMES - 1);
                    end else if (fade_cnt_q == '0) begin
                        fsm_d        = SHOW;
                        enter_show_c = 1'b1;
                    end else begin
                        fade_cnt_d = fade_cnt_q - FADE_W'(1);
                    end
                end
                default: fsm_d = SHOW;
            endcase
        end
    end

`ifdef LAYER_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 0) ? $clog2(2 * BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    // Frame counter; the FB pixel already uses the new frame's count.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (fb_c) begin
            if (enter_show_c || (blink_cnt_q == BLINK_W'(2 * BLINK_FRAMES - 1))) begin
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign hide_c = (blink_cnt_d >= BLINK_W'(BLINK_FRAMES)) ? blink_mask : '0;
`else
    logic unused_c;
    assign unused_c = ^{blink_mask, enter_show_c, 1'(BLINK_FRAMES)};
    assign hide_c   = '0;
`endif

    // Stage 1: qualified hits, addresses, background address, flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit1_q    <= '0;
            addr1_q   <= '0;
            bg1_q     <= '0;
            active1_q <= 1'b0;
            fb1_q     <= 1'b0;
        end else begin
            hit1_q    <= layer_hit & layer_en & ~hide_c;
            addr1_q   <= layer_addr;
            bg1_q     <= ADDR_W'(bg_addr(h_cnt, v_cnt));
            active1_q <= active_c;
            fb1_q     <= fb_c;
        end
    end

    layer_prio_enc #(
        .N_LAYERS (N_LAYERS),
        .ADDR_W   (ADDR_W)
    ) u_prio (
        .hit_i  (hit1_q),
        .addr_i (addr1_q),
        .any_c  (sel_any_c),
        .idx_c  (sel_idx_c),
        .addr_c (sel_addr_c)
    );

    // Output selection; blanking uses the FSM state already updated at FB.
    always_comb begin
        pixel_addr_d  = '0;
        pixel_src_d   = '0;
        pixel_valid_d = 1'b0;
        if (active1_q) begin
            if (sel_any_c) begin
                pixel_src_d = SRC_W'(sel_idx_c) + SRC_W'(1);
            end
            if (fsm_q == SHOW) begin
                pixel_valid_d = 1'b1;
                pixel_addr_d  = sel_any_c ? sel_addr_c : bg1_q;
            end
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr  <= '0;
            pixel_src   <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            shown_state <= '0;
            blanking    <= 1'b0;
        end else begin
            pixel_addr  <= pixel_addr_d;
            pixel_src   <= pixel_src_d;
            pixel_valid <= pixel_valid_d;
            frame_start <= fb1_q;
            shown_state <= shown_q;
            blanking    <= (fsm_q == BLANK);
        end
    end

endmodule
